// File: rtl/audio_pkg.sv
// Shared audio-path defaults used by the clock divider and the I2S transmitter.
package audio_pkg;
  localparam int AUD_DATA_W        = 24;
  localparam int AUD_SLOT_W        = 32;
  localparam int AUD_MCLK_PER_SCLK = 4;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing: MCLK edge detect, SCLK divider and slot bit counter driving SCLK/LRCK.
// Exports the pre-advance bit count plus SCLK-fall and frame-start strobes (both one clk wide).
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int SLOT_W        = AUD_SLOT_W,
  parameter int MCLK_PER_SCLK = AUD_MCLK_PER_SCLK,
  localparam int DIV_W        = $clog2(MCLK_PER_SCLK),
  localparam int CNT_W        = $clog2(2 * SLOT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mclk,
  output logic             sclk,
  output logic             lrck,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             sclk_fall,
  output logic             frame_start
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_SCLK - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_PER_SCLK / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);

  logic             r_mclk_q;
  logic             r_sclk;
  logic             r_lrck;
  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             w_mclk_rise;
  logic [DIV_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_mclk_rise = mclk & ~r_mclk_q;
  assign w_div_nxt   = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
  assign w_cnt_nxt   = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign sclk_fall   = w_mclk_rise & (r_div == DIV_LAST);
  assign frame_start = sclk_fall & (r_bit_cnt == CNT_LAST);

  assign sclk    = r_sclk;
  assign lrck    = r_lrck;
  assign bit_cnt = r_bit_cnt;

  always_ff @(posedge clk) begin
    r_mclk_q <= mclk;
  end

  // SCLK and LRCK are registered from the post-advance counts so they move on the same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_bit_cnt <= '0;
      r_lrck    <= 1'b0;
    end else if (w_mclk_rise) begin
      r_div  <= w_div_nxt;
      r_sclk <= (w_div_nxt >= DIV_HALF);
      if (sclk_fall) begin
        r_bit_cnt <= w_cnt_nxt;
        r_lrck    <= (w_cnt_nxt >= SLOT_LEN);
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-pair holding register behind valid/ready, MSB-first serialiser, underrun flag.
// Outputs registered; s_ready is low while a pair is held and reopens 1 clk after the frame-start load.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_W        = AUD_DATA_W,
  parameter int SLOT_W        = AUD_SLOT_W,
  parameter int MCLK_PER_SCLK = AUD_MCLK_PER_SCLK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mclk,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              sclk,
  output logic              lrck,
  output logic              sdata,
  output logic              underrun
);

  localparam int CNT_W = $clog2(2 * SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_W);

  logic [CNT_W-1:0]  w_bit_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_k;
  logic              w_sclk_fall;
  logic              w_frame_start;
  logic              r_full;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_right;
  logic              r_sdata;
  logic              r_underrun;

  i2s_clk_gen #(
    .SLOT_W        (SLOT_W),
    .MCLK_PER_SCLK (MCLK_PER_SCLK)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .mclk        (mclk),
    .sclk        (sclk),
    .lrck        (lrck),
    .bit_cnt     (w_bit_cnt),
    .sclk_fall   (w_sclk_fall),
    .frame_start (w_frame_start)
  );

  // Slot position of the bit about to be driven at this SCLK fall.
  assign w_cnt_nxt = (w_bit_cnt == CNT_LAST) ? '0 : w_bit_cnt + 1'b1;
  assign w_k       = (w_cnt_nxt >= SLOT_LEN) ? w_cnt_nxt - SLOT_LEN : w_cnt_nxt;

  assign s_ready  = ~r_full;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

  // No bypass: a push on the frame-start clk lands here, the load sees the register empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 1'b0;
      r_hold_l <= '0;
      r_hold_r <= '0;
    end else if (s_valid && !r_full) begin
      r_full   <= 1'b1;
      r_hold_l <= s_left;
      r_hold_r <= s_right;
    end else if (w_frame_start) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_right    <= '0;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start & ~r_full;
      if (w_frame_start) begin
        r_shift <= r_full ? r_hold_l : '0;
        r_right <= r_full ? r_hold_r : '0;
        r_sdata <= 1'b0;
      end else if (w_sclk_fall) begin
        if (w_k == '0) begin
          r_shift <= r_right;
          r_sdata <= 1'b0;
        end else if (w_k <= DATA_LEN) begin
          r_sdata <= r_shift[DATA_W-1];
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end
    end
  end

endmodule
